// File: rtl/radix4_divider_param.sv
// radix4_divider_param: iterative radix-4 integer divider (2 quotient bits per
// cycle) with signed/unsigned modes and RISC-V divide-by-zero and overflow
// results. Only the significant dividend digits are iterated.
// Optional build macro DIV_RESULT_CACHE_EN adds a one-entry cache of the last
// completed operation; a repeat of the same inputs bypasses the divide loop.
//
// Handshake: an operation is accepted on an edge with in_valid && in_ready
// (in_ready is high only in IDLE), and operands and is_signed are latched on
// that edge. The result is offered with out_valid and is held stable until an
// edge with out_valid && out_ready. The result registers keep their values
// after the transfer.
module radix4_divider_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(HALF + 1);
    localparam int SW   = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_SHIFT,
        S_DIVIDE,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t state;

    // Latched request
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             sgn_reg;

    // Prepared operands
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH+1:0] b1, b2, b3;
    logic [CW-1:0]    n_reg, cnt;
    logic             neg_q, neg_r;

    // Precomputed result for special cases and cache hits
    logic             bypass;
    logic [WIDTH-1:0] byp_q, byp_r;

    // Iteration state
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] q_acc;

    // Combinational helpers
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [CW-1:0]    n_calc;
    logic             div_zero, ovf;
    logic [SW-1:0]    shamt;
    logic [WIDTH+1:0] pr;
    logic [1:0]       digit;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] fix_q, fix_r;
    logic             cache_hit;
    logic [WIDTH-1:0] hit_q, hit_r;

    assign in_ready = (state == S_IDLE);

    // Number of radix-4 digits: one more than the index of the highest
    // non-zero bit pair, at least one so a zero dividend still iterates once.
    function automatic logic [CW-1:0] digit_count(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        n = CW'(1);
        for (int i = 0; i < HALF; i++) begin
            if (v[2*i] | v[2*i+1]) n = CW'(i + 1);
        end
        return n;
    endfunction

    // Operand magnitudes, digit count and special-case detection for PREP
    always_comb begin
        a_neg    = sgn_reg & a_reg[WIDTH-1];
        b_neg    = sgn_reg & b_reg[WIDTH-1];
        a_abs    = a_neg ? -a_reg : a_reg;
        b_abs    = b_neg ? -b_reg : b_reg;
        n_calc   = digit_count(a_abs);
        div_zero = (b_reg == '0);
        ovf      = sgn_reg && (a_reg == MIN_INT) && (b_reg == '1);
        shamt    = SW'(2 * (HALF - int'(n_reg)));
    end

    // One radix-4 step: largest digit d with d*b not above the partial remainder
    always_comb begin
        pr = {rem_r, a_sh[WIDTH-1 -: 2]};
        if (pr >= b3) begin
            digit = 2'd3;
            diff  = WIDTH'(pr - b3);
        end else if (pr >= b2) begin
            digit = 2'd2;
            diff  = WIDTH'(pr - b2);
        end else if (pr >= b1) begin
            digit = 2'd1;
            diff  = WIDTH'(pr - b1);
        end else begin
            digit = 2'd0;
            diff  = WIDTH'(pr);
        end
    end

    // Final signed result, or the precomputed one for bypassed operations
    always_comb begin
        if (bypass) begin
            fix_q = byp_q;
            fix_r = byp_r;
        end else begin
            fix_q = neg_q ? -q_acc : q_acc;
            fix_r = neg_r ? -rem_r : rem_r;
        end
    end

`ifdef DIV_RESULT_CACHE_EN
    logic             c_valid;
    logic [WIDTH-1:0] c_a, c_b, c_q, c_r;
    logic             c_s;

    assign cache_hit = c_valid && (c_a == a_reg) && (c_b == b_reg) && (c_s == sgn_reg);
    assign hit_q     = c_q;
    assign hit_r     = c_r;

    // Remember the last completed operation; rst invalidates the entry
    always_ff @(posedge clk) begin
        if (rst) begin
            c_valid <= 1'b0;
            c_a     <= '0;
            c_b     <= '0;
            c_s     <= 1'b0;
            c_q     <= '0;
            c_r     <= '0;
        end else if (state == S_FIXUP) begin
            c_valid <= 1'b1;
            c_a     <= a_reg;
            c_b     <= b_reg;
            c_s     <= sgn_reg;
            c_q     <= fix_q;
            c_r     <= fix_r;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_q     = '0;
    assign hit_r     = '0;
`endif

    // Control FSM and datapath registers. Bypassed operations (special cases
    // and cache hits) go through FIXUP, the single place where the result
    // registers are loaded, which gives them a two-edge latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sgn_reg   <= 1'b0;
            a_mag     <= '0;
            b1        <= '0;
            b2        <= '0;
            b3        <= '0;
            n_reg     <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            bypass    <= 1'b0;
            byp_q     <= '0;
            byp_r     <= '0;
            a_sh      <= '0;
            rem_r     <= '0;
            q_acc     <= '0;
            quotient  <= '0;
            remainder <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg   <= dividend;
                        b_reg   <= divisor;
                        sgn_reg <= is_signed;
                        state   <= S_PREP;
                    end
                end
                S_PREP: begin
                    a_mag <= a_abs;
                    b1    <= {2'b00, b_abs};
                    b2    <= {1'b0, b_abs, 1'b0};
                    b3    <= {2'b00, b_abs} + {1'b0, b_abs, 1'b0};
                    n_reg <= n_calc;
                    cnt   <= n_calc;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    if (cache_hit) begin
                        bypass <= 1'b1;
                        byp_q  <= hit_q;
                        byp_r  <= hit_r;
                        state  <= S_FIXUP;
                    end else if (div_zero) begin
                        bypass <= 1'b1;
                        byp_q  <= '1;
                        byp_r  <= a_reg;
                        state  <= S_FIXUP;
                    end else if (ovf) begin
                        bypass <= 1'b1;
                        byp_q  <= MIN_INT;
                        byp_r  <= '0;
                        state  <= S_FIXUP;
                    end else begin
                        bypass <= 1'b0;
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_sh  <= a_mag << shamt;
                    rem_r <= '0;
                    q_acc <= '0;
                    state <= S_DIVIDE;
                end
                S_DIVIDE: begin
                    rem_r <= diff;
                    q_acc <= {q_acc[WIDTH-3:0], digit};
                    a_sh  <= a_sh << 2;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= S_FIXUP;
                end
                S_FIXUP: begin
                    quotient  <= fix_q;
                    remainder <= fix_r;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
